// File: rtl/trdb_pkg.sv
// Shared constants and types for the trace debug APB control slave.
package trdb_pkg;

    // Register offsets within the 16-byte window (address bits [3:0]).
    localparam logic [3:0] TRDB_CTRL_OFF   = 4'h0;
    localparam logic [3:0] TRDB_STATUS_OFF = 4'h4;
    localparam logic [3:0] TRDB_ONCNT_OFF  = 4'h8;
    localparam logic [3:0] TRDB_OFFCNT_OFF = 4'hC;

    // CTRL register bit positions.
    localparam int unsigned TRDB_CTRL_ACT_BIT     = 0;
    localparam int unsigned TRDB_CTRL_REQ_ON_BIT  = 1;
    localparam int unsigned TRDB_CTRL_REQ_OFF_BIT = 2;

    // STATUS register bit positions.
    localparam int unsigned TRDB_STATUS_EN_BIT   = 0;
    localparam int unsigned TRDB_STATUS_RDY_BIT  = 1;
    localparam int unsigned TRDB_STATUS_BUSY_BIT = 2;
    localparam int unsigned TRDB_STATUS_DROP_BIT = 3;

    // Request pulse generator states.
    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_PULSE,
        REQ_GAP
    } trdb_req_state_e;

    // Which request output the current pulse drives.
    typedef enum logic {
        REQ_DIR_ON,
        REQ_DIR_OFF
    } trdb_req_dir_e;

endpackage

// File: rtl/edge_detect.sv
// Registers an input once, then flags rising/falling edges of that sample.
// The outputs are combinational from two flops, one cycle after the input moves.
module edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic sample_q;
    logic prev_q;

    // Sample the input and keep the previous sample for comparison.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sample_q <= d_i;
            prev_q   <= sample_q;
        end
    end

    assign rise_o = sample_q & ~prev_q;
    assign fall_o = ~sample_q & prev_q;

endmodule

// File: rtl/trdb_apb_ctrl.sv
// APB control slave for the trace encoder: turns CTRL writes into finite
// request pulses separated by a low gap, and reports encoder status and
// saturating trace_enable edge counts back to software.
// APB handshake: zero wait states, pready_o = psel_i & penable_i; a write
// takes effect on the clock edge where psel_i, penable_i and pwrite_i are high.
module trdb_apb_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned REQ_HOLD       = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    input  logic                      trace_enable_i,
    input  logic                      encapsulator_ready_i,
    output logic                      trace_activated_o,
    output logic                      trace_req_on_o,
    output logic                      trace_req_off_o
);

    localparam logic [3:0]       HOLD_INIT = 4'(REQ_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // APB decode
    logic       access;
    logic       addr_err;
    logic       wr_en;
    logic [3:0] reg_off;
    logic       ctrl_wr;
    logic       status_wr;
    logic       oncnt_wr;
    logic       offcnt_wr;
    logic       req_wr;

    assign reg_off   = {paddr_i[3:2], 2'b00};
    assign addr_err  = |paddr_i[APB_ADDR_WIDTH-1:4];
    assign access    = psel_i & penable_i;
    assign pready_o  = access;
    assign pslverr_o = access & addr_err;
    assign wr_en     = access & pwrite_i & ~addr_err;

    assign ctrl_wr   = wr_en & (reg_off == TRDB_CTRL_OFF);
    assign status_wr = wr_en & (reg_off == TRDB_STATUS_OFF);
    assign oncnt_wr  = wr_en & (reg_off == TRDB_ONCNT_OFF);
    assign offcnt_wr = wr_en & (reg_off == TRDB_OFFCNT_OFF);
    assign req_wr    = ctrl_wr & (pwdata_i[TRDB_CTRL_REQ_ON_BIT] | pwdata_i[TRDB_CTRL_REQ_OFF_BIT]);

    // Byte-lane bits of the address and the upper write data have no meaning here.
    logic unused_apb_bits;
    assign unused_apb_bits = ^{paddr_i[1:0], pwdata_i[31:4]};

    // Register state
    trdb_req_state_e  state_q, state_d;
    trdb_req_dir_e    dir_q, dir_d;
    logic [3:0]       hold_q, hold_d;
    logic             req_on_q, req_off_q;
    logic             act_q;
    logic             drop_q;
    logic             drop_set;
    logic [CNT_W-1:0] on_cnt_q, off_cnt_q;
    logic             te_rise, te_fall;

    // Edge detector on trace_enable_i feeds the event counters.
    edge_detect u_te_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (trace_enable_i),
        .rise_o (te_rise),
        .fall_o (te_fall)
    );

    // Request FSM next state: REQ_OFF has priority; requests outside IDLE are dropped.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        drop_set = 1'b0;
        case (state_q)
            REQ_IDLE: begin
                if (req_wr) begin
                    dir_d   = pwdata_i[TRDB_CTRL_REQ_OFF_BIT] ? REQ_DIR_OFF : REQ_DIR_ON;
                    hold_d  = HOLD_INIT;
                    state_d = REQ_PULSE;
                end
            end
            REQ_PULSE: begin
                drop_set = req_wr;
                if (hold_q == 4'd0) begin
                    state_d = REQ_GAP;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            REQ_GAP: begin
                drop_set = req_wr;
                state_d  = REQ_IDLE;
            end
            default: begin
                state_d = REQ_IDLE;
            end
        endcase
    end

    // FSM registers; request outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= REQ_IDLE;
            dir_q     <= REQ_DIR_ON;
            hold_q    <= 4'd0;
            req_on_q  <= 1'b0;
            req_off_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            hold_q    <= hold_d;
            req_on_q  <= (state_d == REQ_PULSE) && (dir_d == REQ_DIR_ON);
            req_off_q <= (state_d == REQ_PULSE) && (dir_d == REQ_DIR_OFF);
        end
    end

    // CTRL.ACT and the sticky DROP flag (a new drop beats a same-cycle clear).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                act_q <= pwdata_i[TRDB_CTRL_ACT_BIT];
            end
            if (drop_set) begin
                drop_q <= 1'b1;
            end else if (status_wr && pwdata_i[TRDB_STATUS_DROP_BIT]) begin
                drop_q <= 1'b0;
            end
        end
    end

    // Saturating edge counters; a software clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            on_cnt_q  <= '0;
            off_cnt_q <= '0;
        end else begin
            if (oncnt_wr) begin
                on_cnt_q <= '0;
            end else if (te_rise && (on_cnt_q != CNT_MAX)) begin
                on_cnt_q <= on_cnt_q + CNT_W'(1);
            end
            if (offcnt_wr) begin
                off_cnt_q <= '0;
            end else if (te_fall && (off_cnt_q != CNT_MAX)) begin
                off_cnt_q <= off_cnt_q + CNT_W'(1);
            end
        end
    end

    // Combinational read mux; zero outside a valid read select.
    always_comb begin
        prdata_o = 32'h0;
        if (psel_i && !pwrite_i && !addr_err) begin
            case (reg_off)
                TRDB_CTRL_OFF: begin
                    prdata_o[TRDB_CTRL_ACT_BIT] = act_q;
                end
                TRDB_STATUS_OFF: begin
                    prdata_o[TRDB_STATUS_EN_BIT]   = trace_enable_i;
                    prdata_o[TRDB_STATUS_RDY_BIT]  = encapsulator_ready_i;
                    prdata_o[TRDB_STATUS_BUSY_BIT] = (state_q != REQ_IDLE);
                    prdata_o[TRDB_STATUS_DROP_BIT] = drop_q;
                end
                TRDB_ONCNT_OFF:  prdata_o = 32'(on_cnt_q);
                TRDB_OFFCNT_OFF: prdata_o = 32'(off_cnt_q);
                default:         prdata_o = 32'h0;
            endcase
        end
    end

    assign trace_activated_o = act_q;
    assign trace_req_on_o    = req_on_q;
    assign trace_req_off_o   = req_off_q;

endmodule

// File: tb/tb_trdb_apb_ctrl.sv
// Bench for trdb_apb_ctrl: directed register/pulse scenarios followed by
// random APB traffic, checked by a monitor against a queue-based model.
module tb_trdb_apb_ctrl;

    localparam int AW   = 12;
    localparam int HOLD = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int EW   = 34;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [31:0]   pwdata;
    logic [31:0]   prdata_o;
    logic          pready_o, pslverr_o;
    logic          te, rdy;
    logic          trace_activated_o, trace_req_on_o, trace_req_off_o;

    trdb_apb_ctrl #(
        .APB_ADDR_WIDTH (AW),
        .REQ_HOLD       (HOLD),
        .CNT_W          (CW)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .paddr_i              (paddr),
        .psel_i               (psel),
        .penable_i            (penable),
        .pwrite_i             (pwrite),
        .pwdata_i             (pwdata),
        .prdata_o             (prdata_o),
        .pready_o             (pready_o),
        .pslverr_o            (pslverr_o),
        .trace_enable_i       (te),
        .encapsulator_ready_i (rdy),
        .trace_activated_o    (trace_activated_o),
        .trace_req_on_o       (trace_req_on_o),
        .trace_req_off_o      (trace_req_off_o)
    );

    // Clock and cycle index (cycle k is the interval after posedge k).
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state and reference model.
    logic [EW-1:0] exp_q[$];
    int            pulse_start_q[$];
    logic          pulse_dir_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic          m_act, m_drop;
    int            m_on, m_off;
    int            busy_until;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_drop = 1'b0; m_on = 0; m_off = 0; busy_until = -10;
        pulse_start_q.delete();
        pulse_dir_q.delete();
    endtask

    // Driver: one full APB transfer (setup then access), model updated after commit.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        err;
        logic [3:0]  off;
        int          c;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        c   = cyc;
        err = (addr[AW-1:4] != 0);
        off = {addr[3:2], 2'b00};
        rd  = 32'h0;
        if (!wr && !err) begin
            case (off)
                4'h0: rd = {31'h0, m_act};
                4'h4: rd = {28'h0, m_drop, (c <= busy_until), rdy, te};
                4'h8: rd = 32'(m_on);
                4'hC: rd = 32'(m_off);
                default: rd = 32'h0;
            endcase
        end
        exp_q.push_back({1'b1, err, rd});
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (wr && !err) begin
            case (off)
                4'h0: begin
                    m_act = data[0];
                    if (data[1] || data[2]) begin
                        if (c <= busy_until) m_drop = 1'b1;
                        else begin
                            busy_until = c + 1 + HOLD;
                            pulse_start_q.push_back(c + 1);
                            pulse_dir_q.push_back(data[2]);
                        end
                    end
                end
                4'h4: if (data[3]) m_drop = 1'b0;
                4'h8: m_on = 0;
                4'hC: m_off = 0;
                default: ;
            endcase
        end
    endtask

    task automatic toggle_te();
        @(posedge clk); #1;
        te = ~te;
        if (te) m_on = sat_inc(m_on);
        else    m_off = sat_inc(m_off);
        repeat (2) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic read_all();
        apb_xfer(1'b0, 12'h000, 32'h0);
        apb_xfer(1'b0, 12'h004, 32'h0);
        apb_xfer(1'b0, 12'h008, 32'h0);
        apb_xfer(1'b0, 12'h00C, 32'h0);
    endtask

    // Reset asserted in the middle of a cycle; request outputs must fall at once.
    task automatic reset_mid_cycle();
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_req_on", trace_req_on_o, 1'b0);
        check("rst_async_req_off", trace_req_off_o, 1'b0);
        check("rst_async_act", trace_activated_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        if (te) m_on = 1;
        idle(3);
    endtask

    // Monitor: APB responses, ACT level and request pulse shape/timing.
    int   run_len = 0;
    logic run_dir = 1'b0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            run_len = 0;
        end else begin
            if (psel && penable) begin
                check("apb_resp_available", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    check("apb_resp", {pready_o, pslverr_o, prdata_o}, exp_q.pop_front());
            end else if (!psel) begin
                check("apb_idle", {pready_o, pslverr_o, prdata_o}, '0);
            end
            check("act", trace_activated_o, m_act);
            check("req_exclusive", trace_req_on_o & trace_req_off_o, 1'b0);
            if (trace_req_on_o || trace_req_off_o) begin
                if (run_len == 0) begin
                    check("pulse_expected", pulse_start_q.size() != 0, 1'b1);
                    if (pulse_start_q.size() != 0) begin
                        check("pulse_start", cyc, pulse_start_q.pop_front());
                        check("pulse_dir", trace_req_off_o, pulse_dir_q.pop_front());
                    end
                    run_dir = trace_req_off_o;
                end else begin
                    check("pulse_dir_stable", trace_req_off_o, run_dir);
                end
                run_len++;
            end else if (run_len != 0) begin
                check("pulse_len", run_len, HOLD);
                run_len = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        rst_ni = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; te = 1'b0; rdy = 1'b1;
        model_reset();
        #3;
        check("reset_outputs",
              {prdata_o, pready_o, pslverr_o, trace_activated_o, trace_req_on_o, trace_req_off_o}, '0);
        idle(2);
        #1;
        rst_ni = 1'b1;
        idle(2);

        // Reset values of all registers.
        read_all();

        // ACT + REQ_ON, STATUS busy read during the pulse.
        apb_xfer(1'b1, 12'h000, 32'h3);
        apb_xfer(1'b0, 12'h004, 32'h0);
        apb_xfer(1'b0, 12'h000, 32'h0);
        idle(4);

        // ACT cleared with REQ_OFF.
        apb_xfer(1'b1, 12'h000, 32'h6);
        idle(5);
        apb_xfer(1'b0, 12'h000, 32'h0);

        // Second request while busy is dropped; DROP then cleared.
        apb_xfer(1'b1, 12'h000, 32'h2);
        apb_xfer(1'b1, 12'h000, 32'h4);
        apb_xfer(1'b0, 12'h004, 32'h0);
        idle(4);
        apb_xfer(1'b0, 12'h004, 32'h0);
        apb_xfer(1'b1, 12'h004, 32'h8);
        apb_xfer(1'b0, 12'h004, 32'h0);

        // Both request bits: OFF wins.
        apb_xfer(1'b1, 12'h000, 32'h7);
        idle(5);

        // Edge counters, saturation and clear.
        for (int i = 0; i < 6; i++) toggle_te();
        apb_xfer(1'b0, 12'h008, 32'h0);
        apb_xfer(1'b0, 12'h00C, 32'h0);
        for (int i = 0; i < 4; i++) toggle_te();
        apb_xfer(1'b0, 12'h008, 32'h0);
        apb_xfer(1'b1, 12'h008, 32'h0);
        apb_xfer(1'b0, 12'h008, 32'h0);
        apb_xfer(1'b0, 12'h00C, 32'h0);

        // Out-of-window accesses.
        apb_xfer(1'b0, 12'h010, 32'h0);
        apb_xfer(1'b1, 12'h010, 32'h7);
        apb_xfer(1'b1, 12'h01C, 32'hFFFF_FFFF);
        idle(4);
        read_all();

        // Reset in the middle of an ON pulse, then FSM must accept a new request.
        apb_xfer(1'b1, 12'h000, 32'h2);
        reset_mid_cycle();
        read_all();
        apb_xfer(1'b1, 12'h000, 32'h2);
        idle(5);
        apb_xfer(1'b0, 12'h004, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1: apb_xfer(1'b1, AW'($urandom_range(0, 3)),
                               ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7)));
                2, 9: begin
                    a = AW'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
                    apb_xfer(1'b0, a, $urandom);
                end
                3: apb_xfer(1'b1, AW'(12'h004 + $urandom_range(0, 3)), $urandom);
                4: apb_xfer(1'b1, ($urandom_range(0, 1) != 0) ? 12'h008 : 12'h00C, $urandom);
                5: toggle_te();
                6: begin
                    @(posedge clk); #1;
                    rdy = ~rdy;
                end
                7: begin
                    a = AW'(($urandom_range(1, 255) << 4) | $urandom_range(0, 15));
                    apb_xfer(1'($urandom_range(0, 1)), a, $urandom);
                end
                default: idle($urandom_range(0, 4));
            endcase
        end

        idle(8);
        read_all();
        idle(4);
        check("exp_q_drained", exp_q.size(), 0);
        check("pulse_q_drained", pulse_start_q.size(), 0);
        check("no_open_pulse", run_len, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
